// File: rtl/fifo_pkg.sv
// +----------------------------------------------------------------------------+
// | fifo_pkg : shared constants and helpers for fifo_flex and status consumers |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package fifo_pkg;

  // Bits needed to encode the values 0 .. value-1. The result is never below 1.
  function automatic int fifo_clog2(input int value);
    int bits;
    bits = 1;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

  // Bit positions of the packed status word.
  localparam int c_stat_empty        = 0;
  localparam int c_stat_almost_empty = 1;
  localparam int c_stat_almost_full  = 2;
  localparam int c_stat_full         = 3;
  localparam int c_stat_overflow     = 4;
  localparam int c_stat_underflow    = 5;
  localparam int c_stat_width        = 6;

  typedef logic [c_stat_width-1:0] fifo_status_t;

endpackage

`default_nettype wire

// File: rtl/fifo_flex_if.sv
// +----------------------------------------------------------------------------+
// | fifo_flex_if : write/read/status bundle of fifo_flex                       |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

interface fifo_flex_if #(
  parameter int NUM_SLOTS  = 4,
  parameter int DATA_WIDTH = 8
);
  import fifo_pkg::*;

  localparam int c_lvl_w = fifo_clog2(NUM_SLOTS + 1);

  logic                  clear;
  logic [DATA_WIDTH-1:0] data_write;
  logic                  write;
  logic                  full;
  logic                  almost_full;
  logic [DATA_WIDTH-1:0] data_read;
  logic                  next_read;
  logic                  empty;
  logic                  almost_empty;
  logic [c_lvl_w-1:0]    level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clear, data_write, write, next_read,
    input  full, almost_full, data_read, empty, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  clear, data_write, write, next_read,
    output full, almost_full, data_read, empty, almost_empty, level, overflow, underflow
  );

endinterface

`default_nettype wire

// File: rtl/fifo_flex_mem.sv
// +----------------------------------------------------------------------------+
// | fifo_flex_mem : NUM_SLOTS x DATA_WIDTH array, sync write, async read       |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module fifo_flex_mem #(
  parameter int NUM_SLOTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  wire logic                  clk,
  input  wire logic                  wr_en,
  input  wire logic [ADDR_WIDTH-1:0] wr_addr,
  input  wire logic [DATA_WIDTH-1:0] wr_data,
  input  wire logic [ADDR_WIDTH-1:0] rd_addr,
  output logic      [DATA_WIDTH-1:0] rd_data
);

  // Storage is deliberately never reset; only the pointers define validity.
  logic [DATA_WIDTH-1:0] r_mem [0:NUM_SLOTS-1];

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/fifo_flex.sv
// +----------------------------------------------------------------------------+
// | fifo_flex : first-word-fall-through FIFO of any depth >= 2 with sticky     |
// |             overflow/underflow flags and configurable almost thresholds    |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module fifo_flex #(
  parameter int NUM_SLOTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int AF_LEVEL   = NUM_SLOTS - 1,
  parameter int AE_LEVEL   = 1
) (
  input wire logic  clk,
  input wire logic  rst,
  fifo_flex_if.slave bus
);
  import fifo_pkg::*;

  localparam int                 c_ptr_w    = fifo_clog2(NUM_SLOTS);
  localparam int                 c_lvl_w    = fifo_clog2(NUM_SLOTS + 1);
  localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(NUM_SLOTS - 1);
  localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
  localparam logic [c_lvl_w-1:0] c_lvl_one  = c_lvl_w'(1);
  localparam logic [c_lvl_w-1:0] c_full_lvl = c_lvl_w'(NUM_SLOTS);
  localparam logic [c_lvl_w-1:0] c_af_lvl   = c_lvl_w'(AF_LEVEL);
  localparam logic [c_lvl_w-1:0] c_ae_lvl   = c_lvl_w'(AE_LEVEL);

  generate
    if (NUM_SLOTS < 2 || AF_LEVEL < 1 || AF_LEVEL > NUM_SLOTS ||
        AE_LEVEL < 0 || AE_LEVEL >= NUM_SLOTS) begin : g_bad_params
      $error("fifo_flex: illegal NUM_SLOTS/AF_LEVEL/AE_LEVEL combination");
    end
  endgenerate

  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_lvl_w-1:0] r_level;
  logic               r_overflow;
  logic               r_underflow;

  logic               w_rd_ok;
  logic               w_wr_ok;
  logic               w_rd_empty;
  logic               w_wr_drop;
  logic               w_mem_we;
  fifo_status_t       w_status;

  function automatic logic [c_ptr_w-1:0] f_ptr_inc(input logic [c_ptr_w-1:0] ptr);
    return (ptr == c_last_ptr) ? '0 : ptr + c_ptr_one;
  endfunction

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign w_rd_ok    = bus.next_read & ~w_status[c_stat_empty];
  assign w_wr_ok    = bus.write & (~w_status[c_stat_full] | w_rd_ok);
  assign w_rd_empty = bus.next_read & w_status[c_stat_empty];
  assign w_wr_drop  = bus.write & ~w_wr_ok;
  assign w_mem_we   = w_wr_ok & ~bus.clear;

  always_comb begin
    w_status                      = '0;
    w_status[c_stat_empty]        = (r_level == '0);
    w_status[c_stat_almost_empty] = (r_level <= c_ae_lvl);
    w_status[c_stat_almost_full]  = (r_level >= c_af_lvl);
    w_status[c_stat_full]         = (r_level == c_full_lvl);
    w_status[c_stat_overflow]     = r_overflow;
    w_status[c_stat_underflow]    = r_underflow;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.clear) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      if (w_rd_ok) r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_level <= r_level + c_lvl_one;
        2'b01:   r_level <= r_level - c_lvl_one;
        default: r_level <= r_level;
      endcase
      if (w_wr_drop)  r_overflow  <= 1'b1;
      if (w_rd_empty) r_underflow <= 1'b1;
    end
  end

  fifo_flex_mem #(
    .NUM_SLOTS  (NUM_SLOTS),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (c_ptr_w)
  ) u_mem (
    .clk     (clk),
    .wr_en   (w_mem_we),
    .wr_addr (r_wr_ptr),
    .wr_data (bus.data_write),
    .rd_addr (r_rd_ptr),
    .rd_data (bus.data_read)
  );

  assign bus.empty        = w_status[c_stat_empty];
  assign bus.almost_empty = w_status[c_stat_almost_empty];
  assign bus.almost_full  = w_status[c_stat_almost_full];
  assign bus.full         = w_status[c_stat_full];
  assign bus.overflow     = w_status[c_stat_overflow];
  assign bus.underflow    = w_status[c_stat_underflow];
  assign bus.level        = r_level;

endmodule

`default_nettype wire

// File: tb/tb_fifo_flex.sv
// +----------------------------------------------------------------------------+
// | tb_fifo_flex : self-checking bench for fifo_flex (5 slots, 8-bit data)     |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fifo_flex;

  localparam int N  = 5;
  localparam int W  = 8;
  localparam int AF = 4;
  localparam int AE = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_flex_if #(.NUM_SLOTS(N), .DATA_WIDTH(W)) bus ();

  fifo_flex #(
    .NUM_SLOTS  (N),
    .DATA_WIDTH (W),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue holding the FIFO contents plus the two sticky flags.
  logic [W-1:0] mq [$];
  bit           m_ovf;
  bit           m_unf;

  typedef struct {
    bit           wr;
    bit           rd;
    logic [W-1:0] d;
    int           lvl;
    bit           emp;
    bit           ful;
    bit           af;
    bit           ae;
    bit           ovf;
    bit           unf;
    logic [W-1:0] head;
    bit           head_valid;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endfunction

  function automatic void model_step(input bit wr, input bit rd, input bit clr, input logic [W-1:0] d);
    bit rd_ok;
    bit wr_ok;
    if (clr) begin
      model_reset();
      return;
    end
    rd_ok = rd && (mq.size() > 0);
    wr_ok = wr && ((mq.size() < N) || rd_ok);
    if (rd && mq.size() == 0) m_unf = 1'b1;
    if (wr && !wr_ok)         m_ovf = 1'b1;
    if (rd_ok) void'(mq.pop_front());
    if (wr_ok) mq.push_back(d);
  endfunction

  // One clock cycle: drive, take the edge, update the model, sample 1 ns later.
  task automatic apply(input bit wr, input bit rd, input bit clr, input logic [W-1:0] d);
    bus.write      = wr;
    bus.next_read  = rd;
    bus.clear      = clr;
    bus.data_write = d;
    @(posedge clk);
    model_step(wr, rd, clr, d);
    #1;
    bus.write     = 1'b0;
    bus.next_read = 1'b0;
    bus.clear     = 1'b0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".level"},        32'(bus.level),        32'(mq.size()));
    chk({tag, ".empty"},        32'(bus.empty),        32'(mq.size() == 0));
    chk({tag, ".full"},         32'(bus.full),         32'(mq.size() == N));
    chk({tag, ".almost_full"},  32'(bus.almost_full),  32'(mq.size() >= AF));
    chk({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(mq.size() <= AE));
    chk({tag, ".overflow"},     32'(bus.overflow),     32'(m_ovf));
    chk({tag, ".underflow"},    32'(bus.underflow),    32'(m_unf));
    if (mq.size() > 0) chk({tag, ".head"}, 32'(bus.data_read), 32'(mq[0]));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".level"},        32'(bus.level),        32'd0);
    chk({tag, ".empty"},        32'(bus.empty),        32'd1);
    chk({tag, ".full"},         32'(bus.full),         32'd0);
    chk({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'd1);
    chk({tag, ".almost_full"},  32'(bus.almost_full),  32'd0);
    chk({tag, ".overflow"},     32'(bus.overflow),     32'd0);
    chk({tag, ".underflow"},    32'(bus.underflow),    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d8;
    bit           wr;
    bit           rd;
    bit           clr;

    bus.write      = 1'b0;
    bus.next_read  = 1'b0;
    bus.clear      = 1'b0;
    bus.data_write = '0;
    model_reset();

    // Fill to full, overflow, pass-through write, drain, underflow.
    //           wr rd d       lvl emp ful af ae ovf unf head   hv
    tbl[0]  = '{1, 0, 8'h10, 1, 0, 0, 0, 1, 0, 0, 8'h10, 1};
    tbl[1]  = '{1, 0, 8'h11, 2, 0, 0, 0, 0, 0, 0, 8'h10, 1};
    tbl[2]  = '{1, 0, 8'h12, 3, 0, 0, 0, 0, 0, 0, 8'h10, 1};
    tbl[3]  = '{1, 0, 8'h13, 4, 0, 0, 1, 0, 0, 0, 8'h10, 1};
    tbl[4]  = '{1, 0, 8'h14, 5, 0, 1, 1, 0, 0, 0, 8'h10, 1};
    tbl[5]  = '{1, 0, 8'hAA, 5, 0, 1, 1, 0, 1, 0, 8'h10, 1};
    tbl[6]  = '{1, 1, 8'hBB, 5, 0, 1, 1, 0, 1, 0, 8'h11, 1};
    tbl[7]  = '{0, 1, 8'h00, 4, 0, 0, 1, 0, 1, 0, 8'h12, 1};
    tbl[8]  = '{0, 1, 8'h00, 3, 0, 0, 0, 0, 1, 0, 8'h13, 1};
    tbl[9]  = '{0, 1, 8'h00, 2, 0, 0, 0, 0, 1, 0, 8'h14, 1};
    tbl[10] = '{0, 1, 8'h00, 1, 0, 0, 0, 1, 1, 0, 8'hBB, 1};
    tbl[11] = '{0, 1, 8'h00, 0, 1, 0, 0, 1, 1, 0, 8'h00, 0};
    tbl[12] = '{0, 1, 8'h00, 0, 1, 0, 0, 1, 1, 1, 8'h00, 0};

    // Power-on reset, outputs checked while reset is still asserted.
    #2 rst = 1'b0;
    #1 chk_reset_outputs("por");
    repeat (2) @(posedge clk);
    #4 rst = 1'b1;
    apply(0, 0, 0, 8'h00);
    chk_model("post_reset_idle");

    for (int i = 0; i < 13; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      apply(tbl[i].wr, tbl[i].rd, 1'b0, tbl[i].d);
      chk({t, ".level"},        32'(bus.level),        32'(tbl[i].lvl));
      chk({t, ".empty"},        32'(bus.empty),        32'(tbl[i].emp));
      chk({t, ".full"},         32'(bus.full),         32'(tbl[i].ful));
      chk({t, ".almost_full"},  32'(bus.almost_full),  32'(tbl[i].af));
      chk({t, ".almost_empty"}, 32'(bus.almost_empty), 32'(tbl[i].ae));
      chk({t, ".overflow"},     32'(bus.overflow),     32'(tbl[i].ovf));
      chk({t, ".underflow"},    32'(bus.underflow),    32'(tbl[i].unf));
      if (tbl[i].head_valid) chk({t, ".head"}, 32'(bus.data_read), 32'(tbl[i].head));
    end

    // Simultaneous write and read while empty: only the write lands.
    apply(0, 0, 1, 8'h00);
    chk_model("clear1");
    apply(1, 1, 0, 8'h55);
    chk("uflow.underflow", 32'(bus.underflow), 32'd1);
    chk("uflow.level",     32'(bus.level),     32'd1);
    chk("uflow.head",      32'(bus.data_read), 32'h55);

    // Build level 3 with overflow set, then clear with a competing write.
    for (int i = 0; i < 4; i++) apply(1, 0, 0, 8'(8'h60 + i));
    apply(1, 0, 0, 8'h77);
    apply(0, 1, 0, 8'h00);
    apply(0, 1, 0, 8'h00);
    chk("preclr.level",    32'(bus.level),    32'd3);
    chk("preclr.overflow", 32'(bus.overflow), 32'd1);
    apply(1, 0, 1, 8'h99);
    chk("clr.level",    32'(bus.level),    32'd0);
    chk("clr.empty",    32'(bus.empty),    32'd1);
    chk("clr.overflow", 32'(bus.overflow), 32'd0);
    apply(0, 0, 0, 8'h00);
    chk("clr.write_dropped", 32'(bus.level), 32'd0);

    // Twelve interleaved writes/reads so both pointers wrap past the last slot.
    apply(1, 0, 0, 8'h00);
    for (int i = 1; i < 12; i++) begin
      chk($sformatf("wrap.head%0d", i - 1), 32'(bus.data_read), 32'(i - 1));
      apply(1, 1, 0, 8'(i));
      chk_model($sformatf("wrap%0d", i));
    end
    chk("wrap.head11", 32'(bus.data_read), 32'h0B);
    apply(0, 1, 0, 8'h00);
    chk_model("wrap_end");

    // Asynchronous reset in the middle of a cycle at level 3.
    for (int i = 0; i < 3; i++) apply(1, 0, 0, 8'(8'hC0 + i));
    chk("arst.pre_level", 32'(bus.level), 32'd3);
    #3 rst = 1'b0;
    #1 chk_reset_outputs("arst");
    model_reset();
    @(posedge clk);
    #4 rst = 1'b1;
    apply(0, 0, 0, 8'h00);
    chk_model("arst_release");

    // Randomised traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      wr  = ($urandom % 100) < 55;
      rd  = ($urandom % 100) < 45;
      clr = ($urandom % 50) == 0;
      d8  = 8'($urandom);
      apply(wr, rd, clr, d8);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_flex.md
FIFO_FLEX -- requirements
Module: fifo_flex

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, the depth; any integer >= 2, power of two not required.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the data width in bits.
REQ-003 SHALL have parameter AF_LEVEL, default NUM_SLOTS-1, the occupancy at or above which almost_full is asserted.
REQ-004 SHALL have parameter AE_LEVEL, default 1, the occupancy at or below which almost_empty is asserted.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1 bit, the reset; asynchronous and active-low.
REQ-007 SHALL have port clear, input, 1 bit, a synchronous flush.
REQ-008 SHALL have port data_write, input, DATA_WIDTH bits, the write data.
REQ-009 SHALL have port write, input, 1 bit, the write request.
REQ-010 SHALL have port full, output, 1 bit, asserted when level == NUM_SLOTS.
REQ-011 SHALL have port almost_full, output, 1 bit, asserted when level >= AF_LEVEL.
REQ-012 SHALL have port data_read, output, DATA_WIDTH bits, the head of the FIFO (combinational, first-word-fall-through).
REQ-013 SHALL have port next_read, input, 1 bit, which discards the head.
REQ-014 SHALL have port empty, output, 1 bit, asserted when level == 0.
REQ-015 SHALL have port almost_empty, output, 1 bit, asserted when level <= AE_LEVEL.
REQ-016 SHALL have port level, output, clog2(NUM_SLOTS+1) bits, the current occupancy.
REQ-017 SHALL have port overflow, output, 1 bit, a sticky flag for a dropped write.
REQ-018 SHALL have port underflow, output, 1 bit, a sticky flag for a read while empty.

Function
REQ-019 SHALL accept a write when write=1 and either full=0, or full=1 with next_read=1 accepted in the same cycle.
REQ-020 SHALL store an accepted write at write_ptr and advance write_ptr by one, wrapping from NUM_SLOTS-1 to 0.
REQ-021 SHALL accept a read when next_read=1 and empty=0, advancing read_ptr with the same wrap rule.
REQ-022 SHALL ignore next_read while empty: pointers and level unchanged, underflow set.
REQ-023 SHALL drop write while full when no read is accepted in that cycle: storage unchanged, overflow set.
REQ-024 SHALL update level as +1 on a lone accepted write, -1 on a lone accepted read, and unchanged on a simultaneous accepted write and read.
REQ-025 SHALL, on a simultaneous write and read while empty, accept the write only; the read is treated as underflow.
REQ-026 SHALL make data written in cycle N visible on data_read in cycle N+1 (one-cycle write-to-read latency).
REQ-027 SHALL leave data_read undefined while empty; it need not be held.
REQ-028 SHALL derive every status output combinationally from registered level, so flags change only on clock edges.
REQ-029 SHALL, when clear=1, zero the pointers, level, overflow and underflow at the next edge, taking priority over write and next_read; storage contents need not be cleared.
REQ-030 SHALL keep overflow and underflow set until clear or reset.
REQ-031 SHALL fail elaboration unless 1 <= AF_LEVEL <= NUM_SLOTS and 0 <= AE_LEVEL < NUM_SLOTS.

Reset
REQ-032 SHALL, while rst=0, immediately force read_ptr=0, write_ptr=0, level=0, overflow=0 and underflow=0, independent of clk.
REQ-033 SHALL show these output values during reset: empty=1, full=0, almost_empty=1, almost_full=0 (AF_LEVEL >= 1), level=0.
REQ-034 SHALL not reset the storage array.
REQ-035 SHALL abandon any in-flight operation when reset is asserted mid-operation, and SHALL accept no write or read in the first edge after rst deasserts unless write/next_read are high on that edge.

Structure
REQ-036 SHALL place the shared package fifo_pkg with the pointer-width function (clog2 helper) and the status-flag bit positions used by debug/status consumers.
REQ-037 SHALL use one sub-module, fifo_flex_mem: a NUM_SLOTS x DATA_WIDTH register array with one synchronous write port and one asynchronous read port.
REQ-038 SHALL keep pointer, level and flag logic in fifo_flex itself.

Verification
REQ-039 SHALL cover fill to full: NUM_SLOTS=5, DATA_WIDTH=8, AF_LEVEL=4, AE_LEVEL=1; write 0x10..0x14 -> almost_full at level 4, full at level 5, then read order 0x10..0x14 with no overflow.
REQ-040 SHALL cover wrap-around: NUM_SLOTS=5; 12 interleaved writes/reads of 0x00..0x0B -> read sequence identical, pointers pass 4->0, level never exceeds 5.
REQ-041 SHALL cover overflow/pass-through: full with head 0x10; write 0xAA alone -> overflow=1, level 5; write 0xBB with next_read -> level 5, 0xBB stored as last entry.
REQ-042 SHALL cover underflow: empty; next_read=1 with write=1 of 0x55 -> underflow=1, level=1, data_read=0x55 next cycle.
REQ-043 SHALL cover clear: level 3 with overflow=1; clear=1 with write=1 -> level 0, empty=1, overflow=0, write dropped.
REQ-044 SHALL cover asynchronous reset: assert rst=0 mid-cycle at level 3 -> empty=1 and level=0 before the next clk edge.
